// File: rtl/a_bus_arbiter.sv
// a_bus_arbiter: two-master arbiter with bounded M2 borrowing while M1's slave stalls
module a_bus_arbiter #(
    parameter int MAX_BORROW = 256
) (
    input  logic clk,
    input  logic rstN,
    input  logic req1,
    input  logic req2,
    input  logic done1,
    input  logic done2,
    input  logic thresh,
    output logic grant1,
    output logic grant2,
    output logic suspend1,
    output logic abort2,
    output logic busy
);
    localparam int CW = $clog2(MAX_BORROW) + 1;

    // RETURN_ABORT is the bubble cycle reached by borrow expiry; it carries abort2
    typedef enum logic [2:0] {IDLE, GRANT1, GRANT2, BORROW, RETURN, RETURN_ABORT} state_t;

    state_t state, next;
    logic [CW-1:0] cnt;
    logic expired;

    assign expired = cnt == CW'(MAX_BORROW - 1);

    // state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= next;
    end

    // borrow age: counts while staying in BORROW, cleared everywhere else
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) cnt <= '0;
        else       cnt <= (state == BORROW && next == BORROW) ? cnt + 1'b1 : '0;
    end

    // next-state: done releases always win over thresh/expiry
    always_comb begin
        next = state;
        case (state)
            IDLE:         next = req1 ? GRANT1 : req2 ? GRANT2 : IDLE;
            GRANT1:       next = done1 ? IDLE : (thresh && req2) ? BORROW : GRANT1;
            GRANT2:       next = done2 ? IDLE : GRANT2;
            BORROW:       next = done2 ? RETURN : expired ? RETURN_ABORT : BORROW;
            RETURN:       next = GRANT1;
            RETURN_ABORT: next = GRANT1;
            default:      next = IDLE;
        endcase
    end

    assign grant1   = state == GRANT1;
    assign grant2   = state == GRANT2 || state == BORROW;
    assign suspend1 = state == BORROW || state == RETURN || state == RETURN_ABORT;
    assign abort2   = state == RETURN_ABORT;
    assign busy     = grant1 | grant2;
endmodule

// File: tb/tb_a_bus_arbiter.sv
// tb_a_bus_arbiter: random + directed check of a_bus_arbiter against an owner-based model
module tb_a_bus_arbiter;
    localparam int MB = 4;

    logic clk = 0, rstN = 0;
    logic req1 = 0, req2 = 0, done1 = 0, done2 = 0, thresh = 0;
    logic grant1, grant2, suspend1, abort2, busy;

    int vectors = 0, miscompares = 0;

    a_bus_arbiter #(.MAX_BORROW(MB)) dut (
        .clk(clk), .rstN(rstN), .req1(req1), .req2(req2), .done1(done1), .done2(done2),
        .thresh(thresh), .grant1(grant1), .grant2(grant2), .suspend1(suspend1),
        .abort2(abort2), .busy(busy)
    );

    always #5 clk = ~clk;

    // model: who owns the bus, whether M2 is on loan, and a pending return bubble
    int owner = 0;
    int age = 0;
    bit borrowed = 0, bubble = 0, aborted = 0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            owner = 0; age = 0; borrowed = 0; bubble = 0; aborted = 0;
        end else if (bubble) begin
            bubble = 0; aborted = 0; owner = 1;
        end else if (owner == 0) begin
            owner = req1 ? 1 : req2 ? 2 : 0;
        end else if (owner == 1) begin
            if (done1) owner = 0;
            else if (thresh && req2) begin owner = 2; borrowed = 1; age = 0; end
        end else if (borrowed) begin
            if (done2 || age == MB - 1) begin
                aborted = !done2; owner = 0; borrowed = 0; bubble = 1;
            end else age++;
        end else if (done2) owner = 0;
    end

    function automatic logic [4:0] model_out();
        logic g1, g2;
        g1 = owner == 1;
        g2 = owner == 2;
        return {g1, g2, borrowed || bubble, bubble && aborted, g1 | g2};
    endfunction

    // every cycle: DUT outputs {grant1,grant2,suspend1,abort2,busy} against the model
    always @(negedge clk) begin
        vectors++;
        if ({grant1, grant2, suspend1, abort2, busy} !== model_out()) begin
            miscompares++;
            $display("FAIL model t=%0t dut=%b expected=%b", $time,
                     {grant1, grant2, suspend1, abort2, busy}, model_out());
        end
    end

    task automatic lit(input string name, input logic [4:0] exp);
        vectors++;
        if ({grant1, grant2, suspend1, abort2, busy} !== exp || model_out() !== exp) begin
            miscompares++;
            $display("FAIL %s dut=%b model=%b expected=%b", name,
                     {grant1, grant2, suspend1, abort2, busy}, model_out(), exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [4:0] O_IDLE = 5'b00000, O_G1 = 5'b10001, O_G2 = 5'b01001,
                           O_BOR = 5'b01101, O_RET = 5'b00100, O_ABT = 5'b00110;

    initial begin
        cyc(2);
        lit("reset", O_IDLE);
        rstN = 1;
        // simple M1 grant and release
        req1 = 1; cyc; lit("g1_latency", O_G1);
        req1 = 0; cyc(3); lit("g1_hold", O_G1);
        done1 = 1; cyc; done1 = 0; lit("g1_release", O_IDLE);
        // both requesting: M1 first, one idle cycle, then M2 held past req2 drop
        req1 = 1; req2 = 1; cyc; lit("both_g1", O_G1);
        req1 = 0; done1 = 1; cyc; done1 = 0; lit("turnaround", O_IDLE);
        cyc; lit("then_g2", O_G2);
        req2 = 0; req1 = 1; cyc(3); lit("g2_nonpreempt", O_G2);
        req1 = 0; done2 = 1; cyc; done2 = 0; lit("g2_release", O_IDLE);
        // borrow ended by done2
        req1 = 1; cyc; req1 = 0; lit("pre_borrow", O_G1);
        req2 = 1; thresh = 1; cyc; thresh = 0; lit("borrow", O_BOR);
        cyc(2); done2 = 1; cyc; done2 = 0; lit("return", O_RET);
        cyc; lit("back_g1", O_G1);
        // borrow expiry: 4 cycles of grant2, then abort bubble
        thresh = 1; cyc; thresh = 0; lit("exp_b0", O_BOR);
        cyc; lit("exp_b1", O_BOR);
        cyc; lit("exp_b2", O_BOR);
        cyc; lit("exp_b3", O_BOR);
        cyc; lit("abort", O_ABT);
        cyc; lit("abort_back_g1", O_G1);
        // done1 with thresh: release wins
        done1 = 1; thresh = 1; cyc; done1 = 0; thresh = 0; lit("done1_wins", O_IDLE);
        cyc; req2 = 0; lit("idle_to_g2", O_G2);
        done2 = 1; cyc; done2 = 0; lit("g2_done", O_IDLE);
        // done2 on expiry cycle: no abort
        req1 = 1; cyc; req1 = 0; req2 = 1; thresh = 1; cyc; thresh = 0; lit("b_again", O_BOR);
        cyc(3); lit("b_last", O_BOR);
        done2 = 1; cyc; done2 = 0; lit("done2_on_expiry", O_RET);
        cyc; lit("after_ret", O_G1);
        // async reset mid-borrow
        thresh = 1; cyc; thresh = 0; req2 = 0; lit("b_pre_reset", O_BOR);
        #2 rstN = 0; #1 lit("async_reset", O_IDLE);
        cyc; rstN = 1; cyc(2); lit("idle_after_reset", O_IDLE);
        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            req1   = $urandom_range(0, 2) == 0;
            req2   = $urandom_range(0, 1) == 0;
            done1  = $urandom_range(0, 5) == 0;
            done2  = $urandom_range(0, 6) == 0;
            thresh = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 999) == 0) begin
                #2 rstN = 0; #1 lit("rand_reset", O_IDLE);
                rstN = 1;
            end
            cyc;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/a_bus_arbiter.md
Name: a_bus_arbiter

Overview:
- Two-master bus arbiter that consumes the slave-stall `thresh` flag from the threshold counter.
- Grants the bus to the high-priority master (M1) by default.
- When M1's slave stalls past threshold, M1 is suspended and the low-priority master (M2) borrows the bus for a bounded time.
- Sits between both masters and the shared bus mux; its grants drive the mux selects.

Parameters:
- MAX_BORROW, 256: maximum cycles M2 may hold a borrowed bus before forced return to M1 (range 2..2^16).

Ports:
- clk  input  1  system clock, rising edge
- rstN  input  1  asynchronous active-low reset
- req1  input  1  M1 (high-priority) bus request, level
- req2  input  1  M2 (low-priority) bus request, level
- done1  input  1  M1 transaction complete, 1-cycle pulse
- done2  input  1  M2 transaction complete, 1-cycle pulse
- thresh  input  1  slave-ready delay exceeded (threshold counter output)
- grant1  output  1  M1 owns bus
- grant2  output  1  M2 owns bus
- suspend1  output  1  M1 must freeze its transaction state
- abort2  output  1  1-cycle pulse: M2 borrow expired, M2 must abandon its transaction
- busy  output  1  any grant active

Behaviour:
- Clock and reset: single clock clk; reset rstN is asynchronous, active-low.
- Reset: state=IDLE, borrow counter=0, all outputs 0; applies immediately, including mid-transaction.
- All outputs are registered (decoded from state register); no combinational input-to-output path.
- Invariant: grant1 and grant2 are never both 1.
- IDLE:
  - req1 → GRANT1.
  - else req2 → GRANT2.
  - Both requesting → GRANT1.
  - Grant visible the cycle after the request is sampled (1-cycle latency).
- GRANT1 (grant1=1):
  - done1 → IDLE.
  - else thresh && req2 → BORROW.
  - thresh without req2 → stay.
  - done1 and thresh in the same cycle → done1 wins (IDLE).
- BORROW (grant2=1, suspend1=1, grant1=0):
  - Counter increments each cycle from 0.
  - done2 → RETURN.
  - else counter == MAX_BORROW-1 → RETURN with abort2 pulsed during the single RETURN cycle.
  - done2 on the expiry cycle → done2 wins, no abort2.
  - thresh ignored in this state.
- RETURN (all grants 0, suspend1=1):
  - Exactly one bubble cycle, then GRANT1 with suspend1=0.
  - Counter cleared.
- GRANT2 (grant2=1):
  - Non-preemptive: req1 does not interrupt.
  - done2 → IDLE.
  - thresh ignored (M2 has nothing to yield to except waiting).
- Request handling: dropping req without done does not release a grant; done is the only release. done for a non-granted master is ignored.
- Turnaround: every release passes through IDLE or RETURN, so there is a minimum 1 idle cycle between grants.
- busy = grant1 | grant2.
- Counter width: clog2(MAX_BORROW)+1 bits; never wraps (cleared on leaving BORROW).

Test Plan:
- Reset, req1=1 at cycle 0 → grant1=1 at cycle 1. done1 at cycle 5 → grant1=0 at cycle 6, busy=0.
- req1=req2=1 in IDLE → grant1 first. done1 → one IDLE cycle, then grant2=1. grant2 holds until done2 even if req2 drops.
- GRANT1, req2=1, thresh rises at cycle 10 → cycle 11: grant2=1, suspend1=1, grant1=0. done2 at cycle 20 → cycle 21: RETURN, all grants 0. Cycle 22: grant1=1, suspend1=0.
- MAX_BORROW=4, borrow with no done2 → grant2 high exactly 4 cycles. Next cycle: abort2=1 for 1 cycle, grants 0. Then grant1=1.
- Same-cycle conflicts:
  - done1 with thresh → IDLE, no borrow.
  - done2 on expiry cycle → abort2 stays 0.
- rstN pulsed low mid-BORROW → all outputs 0 asynchronously. After release, idle until new req.
